// File: rtl/req_ack_arbiter_pkg.sv
// Shared types and defaults for the round-robin req/ack arbiter (package arb_pkg).
// Optional assertions in the top are enabled with ARB_SVA_EN.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   localparam int ARB_N       = 4;
   localparam int ARB_TIMEOUT = 8;

   // Index width that still works for a degenerate count of 1.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [$clog2(ARB_N)-1:0] ptr_t;

endpackage

// File: rtl/req_ack_arbiter_if.sv
// Requester/resource signal bundle for req_ack_arbiter.
// master = arbiter side, slave = requesters plus resource.
interface req_ack_arbiter_if
   import arb_pkg::*;
#(
   parameter int N = ARB_N
) ();

   localparam int W = ptr_w(N);

   logic [N-1:0] req;
   logic [N-1:0] ack;
   logic         res_req;
   logic [W-1:0] res_sel;
   logic         res_ack;
   logic         busy;
   logic         timeout_err;

   modport master (
      input  req, res_ack,
      output ack, res_req, res_sel, busy, timeout_err
   );

   modport slave (
      output req, res_ack,
      input  ack, res_req, res_sel, busy, timeout_err
   );

endinterface

// File: rtl/req_ack_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);

   localparam logic [W:0] N_EXT = (W+1)'(N);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [W-1:0]   off;
   logic [W:0]     sum;

   // Doubling the vector turns the wrap-around search into a plain slice.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr +: N];

   always_comb begin
      valid = 1'b0;
      off   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            valid = 1'b1;
            off   = W'(i);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= N_EXT) begin
         sum = sum - N_EXT;
      end
      idx = sum[W-1:0];
   end

endmodule

// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one req/ack resource among N requesters, with WAIT timeout.
// Define ARB_SVA_EN to compile in the embedded protocol assertions.
module req_ack_arbiter
   import arb_pkg::*;
#(
   parameter int N       = ARB_N,
   parameter int TIMEOUT = ARB_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   req_ack_arbiter_if.master bus
);

   localparam int             W        = ptr_w(N);
   localparam int             CW       = ptr_w(TIMEOUT);
   localparam logic [W-1:0]   SEL_LAST = W'(N - 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   arb_state_e    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [W-1:0]  ptr_reg, ptr_next;
   logic [W-1:0]  sel_reg, sel_next;
   logic [W-1:0]  sel_inc;
   logic          terr_reg, terr_next;
   logic          pick_valid;
   logic [W-1:0]  pick_idx;

   rr_pick #(.N(N), .W(W)) u_pick (
      .req   (bus.req),
      .ptr   (ptr_reg),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign sel_inc = (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         ptr_reg   <= '0;
         sel_reg   <= '0;
         terr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         ptr_reg   <= ptr_next;
         sel_reg   <= sel_next;
         terr_reg  <= terr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ptr_next   = ptr_reg;
      sel_next   = sel_reg;
      terr_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_valid) begin
               sel_next   = pick_idx;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            // A late res_ack on the final WAIT cycle still beats the timeout.
            if (bus.res_ack) begin
               state_next = DONE;
            end else if (cnt_reg == CNT_LAST) begin
               terr_next  = 1'b1;
               ptr_next   = sel_inc;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            ptr_next   = sel_inc;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.res_req     = (state_reg == ISSUE);
   assign bus.busy        = (state_reg != IDLE);
   assign bus.res_sel     = sel_reg;
   assign bus.timeout_err = terr_reg;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ack
         assign bus.ack[gi] = (state_reg == DONE) && (sel_reg == W'(gi));
      end
   endgenerate

`ifdef ARB_SVA_EN
   a_ack_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(bus.ack));
   a_res_req_pulse : assert property (@(posedge clk) disable iff (!rst) bus.res_req |=> !bus.res_req);
   // timeout_err is registered, so it lands one cycle after the last WAIT cycle.
   a_res_resolves : assert property (@(posedge clk) disable iff (!rst)
      bus.res_req |-> ##[1:TIMEOUT+1] (bus.res_ack || bus.timeout_err));
   a_idle_not_busy : assert property (@(posedge clk) disable iff (!rst)
      (state_reg == IDLE) |-> !bus.busy);
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_sva_ack
         a_ack_had_req : assert property (@(posedge clk) disable iff (!rst)
            bus.ack[gi] |-> $past(bus.req[gi], 2));
      end
   endgenerate
`endif

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Scoreboard bench for req_ack_arbiter: directed stimulus pushes expected ack/timeout
// events into a queue, an independent monitor pops and compares them.
module tb_req_ack_arbiter;

   typedef struct {
      bit is_timeout;
      int idx;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   ack_delay;
   int   pend;
   exp_t exp_q[$];

   req_ack_arbiter_if #(.N(4)) bus ();

   req_ack_arbiter #(.N(4), .TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One negedge step: requesters drop req on ack, resource answers after ack_delay.
   task automatic tick();
      @(negedge clk);
      if (!rst) begin
         pend        = 0;
         bus.res_ack = 1'b0;
      end else begin
         bus.req     = bus.req & ~bus.ack;
         bus.res_ack = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) bus.res_ack = 1'b1;
         end
         if (bus.res_req && ack_delay > 0) pend = ack_delay;
      end
   endtask

   task automatic check(input string name, input int act, input int req_v);
      checks++;
      if (act != req_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req_v, $time);
      end
   endtask

   task automatic push(input bit is_to, input int idx);
      exp_t e;
      e.is_timeout = is_to;
      e.idx        = idx;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((bus.busy || exp_q.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      check({name, "_idle_bound"}, (n < 100) ? 1 : 0, 1);
      tick();
   endtask

   task automatic wait_res_req(input string name);
      int n;
      n = 0;
      while (!bus.res_req && n < 20) begin
         tick();
         n++;
      end
      check({name, "_res_req_bound"}, (n < 20) ? 1 : 0, 1);
   endtask

   // Monitor: pops one expected event per ack/timeout pulse.
   initial begin
      exp_t        e;
      logic [3:0]  exp_ack;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("ack_onehot0", $onehot0(bus.ack) ? 1 : 0, 1);
            if (bus.ack != 4'b0 || bus.timeout_err) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_event: ack=%b timeout_err=%b required none",
                           bus.ack, bus.timeout_err);
               end else begin
                  e       = exp_q.pop_front();
                  exp_ack = e.is_timeout ? 4'b0000 : 4'(1 << e.idx);
                  if (bus.ack != exp_ack || bus.timeout_err != e.is_timeout
                      || int'(bus.res_sel) != e.idx) begin
                     errors++;
                     $display("FAIL txn_event: ack=%b terr=%b sel=%0d required ack=%b terr=%b sel=%0d",
                              bus.ack, bus.timeout_err, bus.res_sel, exp_ack, e.is_timeout, e.idx);
                  end else begin
                     $display("txn t=%0t ack=%b timeout_err=%b sel=%0d ok",
                              $time, bus.ack, bus.timeout_err, bus.res_sel);
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst         = 1'b0;
      bus.req     = 4'b0000;
      bus.res_ack = 1'b0;
      checks      = 0;
      errors      = 0;
      ack_delay   = 1;
      pend        = 0;

      // Reset state and quiet idle after release.
      #20;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_res_req", int'(bus.res_req), 0);
      check("rst_ack", int'(bus.ack), 0);
      check("rst_res_sel", int'(bus.res_sel), 0);
      check("rst_timeout_err", int'(bus.timeout_err), 0);
      #30 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle_busy", int'(bus.busy), 0);
         check("idle_res_req", int'(bus.res_req), 0);
      end

      // Single request, fastest resource: ack three cycles after sampling.
      ack_delay = 1;
      push(1'b0, 0);
      bus.req = 4'b0001;
      tick();
      check("lat_res_req", int'(bus.res_req), 1);
      check("lat_res_sel", int'(bus.res_sel), 0);
      tick();
      check("lat_wait_busy", int'(bus.busy), 1);
      check("lat_wait_no_ack", int'(bus.ack), 0);
      tick();
      check("lat_ack", int'(bus.ack), 1);
      wait_idle("single");

      // ptr=1 now; a single-cycle reset returns it to 0 for the ordering test.
      #2 rst = 1'b0;
      tick();
      #2 rst = 1'b1;
      tick();

      // All four requesting: strict order 0,1,2,3.
      for (int i = 0; i < 4; i++) push(1'b0, i);
      bus.req = 4'b1111;
      wait_idle("all_four");
      check("all_four_req_cleared", int'(bus.req), 0);

      // Silent resource: one timeout on requester 0, then 1 and 0 are served.
      ack_delay = 0;
      push(1'b1, 0);
      push(1'b0, 1);
      push(1'b0, 0);
      bus.req = 4'b0011;
      wait_res_req("timeout");
      check("timeout_sel", int'(bus.res_sel), 0);
      n = 0;
      while (!bus.timeout_err && n < 20) begin
         tick();
         n++;
      end
      check("timeout_cycles_after_issue", n, 9);
      check("timeout_no_ack", int'(bus.ack), 0);
      ack_delay = 1;
      wait_idle("timeout");

      // res_ack on the final WAIT cycle: ack wins, no timeout_err.
      ack_delay = 8;
      push(1'b0, 1);
      bus.req = 4'b0010;
      wait_res_req("last_wait");
      check("last_wait_sel", int'(bus.res_sel), 1);
      wait_idle("last_wait");

      // Reset during WAIT clears outputs immediately; regrant searches from 0.
      ack_delay = 0;
      bus.req = 4'b0100;
      wait_res_req("rst_wait");
      tick();
      tick();
      check("pre_rst_busy", int'(bus.busy), 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_busy", int'(bus.busy), 0);
      check("async_rst_res_req", int'(bus.res_req), 0);
      check("async_rst_ack", int'(bus.ack), 0);
      check("async_rst_res_sel", int'(bus.res_sel), 0);
      tick();
      tick();
      ack_delay = 1;
      push(1'b0, 2);
      #2 rst = 1'b1;
      wait_res_req("post_rst");
      check("post_rst_sel", int'(bus.res_sel), 2);
      wait_idle("post_rst");

      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
